// File: rtl/ps2_scan_capture.sv
// PS/2 device-to-host receiver: conditions the raw clock/data lines, deserializes
// 11-bit frames, checks stop bit and odd parity, and keeps a 4-byte scan history.
module ps2_scan_capture #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [31:0] data,
  output logic [7:0]  last_byte,
  output logic        byte_valid,
  output logic        parity_err,
  output logic        frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_PAR  = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;

  logic          ck_s1, ck_s2, dt_s1, dt_s2;
  logic [FW-1:0] flt_cnt;
  logic          ck_flt, ck_flt_q;
  logic          fall;
  logic [1:0]    state;
  logic [7:0]    shreg;
  logic [2:0]    bcnt;
  logic          par;
  logic [TW-1:0] to_cnt;
  logic          tout;

  // Two-flop synchronizers; reset to the idle-high line level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ck_s1 <= 1'b1;
      ck_s2 <= 1'b1;
      dt_s1 <= 1'b1;
      dt_s2 <= 1'b1;
    end else begin
      ck_s1 <= ps2_clk;
      ck_s2 <= ck_s1;
      dt_s1 <= ps2_data;
      dt_s2 <= dt_s1;
    end
  end

  // Clock deglitch: flip only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flt_cnt  <= '0;
      ck_flt   <= 1'b1;
      ck_flt_q <= 1'b1;
    end else begin
      ck_flt_q <= ck_flt;
      if (ck_s2 == ck_flt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        ck_flt  <= ck_s2;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign fall = ck_flt_q & ~ck_flt;
  // Timeout wins over a coincident edge so an aborted frame never consumes it
  assign tout = (state != S_IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Frame FSM, timeout watchdog, history register and one-cycle strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      shreg      <= '0;
      bcnt       <= '0;
      par        <= 1'b0;
      to_cnt     <= '0;
      data       <= '0;
      last_byte  <= '0;
      byte_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (tout) begin
        state     <= S_IDLE;
        to_cnt    <= '0;
        frame_err <= 1'b1;
      end else if (fall) begin
        to_cnt <= '0;
        case (state)
          S_IDLE: begin
            if (!dt_s2) begin
              state <= S_DATA;
              bcnt  <= '0;
            end
          end
          S_DATA: begin
            shreg <= {dt_s2, shreg[7:1]};
            bcnt  <= bcnt + 1'b1;
            if (bcnt == 3'd7) state <= S_PAR;
          end
          S_PAR: begin
            par   <= dt_s2;
            state <= S_STOP;
          end
          default: begin
            state <= S_IDLE;
            if (!dt_s2) begin
              frame_err <= 1'b1;
            end else if (~^{shreg, par}) begin
              parity_err <= 1'b1;
            end else begin
              data       <= {data[23:0], shreg};
              last_byte  <= shreg;
              byte_valid <= 1'b1;
            end
          end
        endcase
      end else if (state != S_IDLE) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_capture.sv
// Directed + randomized bench for ps2_scan_capture with a frame-level reference model.
module tb_ps2_scan_capture;

  localparam int FL   = 8;
  localparam int TO   = 2000;
  localparam int HALF = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [31:0] data;
  logic [7:0]  last_byte;
  logic        byte_valid, parity_err, frame_err;

  ps2_scan_capture #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .data(data), .last_byte(last_byte), .byte_valid(byte_valid),
    .parity_err(parity_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // strobe monitor, sampled away from the active edge
  int nbv = 0, npe = 0, nfe = 0, nmulti = 0, fe_cyc = 0;
  always @(negedge clk) begin
    if (byte_valid) nbv++;
    if (parity_err) npe++;
    if (frame_err) begin nfe++; fe_cyc = cyc; end
    if (int'(byte_valid) + int'(parity_err) + int'(frame_err) > 1) nmulti++;
  end

  int errs = 0, checks = 0;
  logic [31:0] hist = '0;
  logic [7:0]  lastb = '0;
  int last_fall = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // one PS/2 bit: data set while clock high, optional 3-cycle low glitch mid-high
  task automatic send_bit(input logic b, input bit gl);
    ps2_data = b;
    if (gl) begin
      tick(HALF / 2);
      ps2_clk = 1'b0; tick(3); ps2_clk = 1'b1;
      tick(HALF / 2 - 3);
    end else begin
      tick(HALF);
    end
    ps2_clk = 1'b0;
    last_fall = cyc;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit pflip, input logic stop);
    logic p;
    p = (($countones(b) % 2) == 0) ^ pflip;
    return {stop, p, b, 1'b0};
  endfunction

  // send a full frame, apply the frame rules to the model, compare everything
  task automatic frame_check(input string tag, input logic [7:0] b, input bit pflip,
                             input logic stop, input bit gl);
    logic [10:0] f;
    int bv0, pe0, fe0, ebv, epe, efe;
    f = mk_frame(b, pflip, stop);
    bv0 = nbv; pe0 = npe; fe0 = nfe;
    ebv = 0; epe = 0; efe = 0;
    for (int i = 0; i < 11; i++) send_bit(f[i], gl);
    tick(HALF);
    if (!stop) efe = 1;
    else if ((($countones(b) + int'(f[9])) % 2) == 0) epe = 1;
    else begin ebv = 1; hist = {hist[23:0], b}; lastb = b; end
    chk({tag, ".bv"}, nbv - bv0, ebv);
    chk({tag, ".pe"}, npe - pe0, epe);
    chk({tag, ".fe"}, nfe - fe0, efe);
    chk({tag, ".data"}, data, hist);
    chk({tag, ".last"}, {24'd0, last_byte}, {24'd0, lastb});
  endtask

  initial begin
    logic [10:0] f;
    int bv0, pe0, fe0, t0, dly;
    logic [7:0] rb;
    int r;

    #2 reset = 1'b1;
    tick(4);
    chk("rst.data", data, 32'd0);
    chk("rst.last", {24'd0, last_byte}, 32'd0);
    chk("rst.strb", {29'd0, byte_valid, parity_err, frame_err}, 32'd0);
    reset = 1'b0;
    tick(20);

    // basic frame and history fill / wrap
    frame_check("f1c", 8'h1C, 0, 1'b1, 0);
    frame_check("ff0", 8'hF0, 0, 1'b1, 0);
    frame_check("f1c2", 8'h1C, 0, 1'b1, 0);
    frame_check("f32", 8'h32, 0, 1'b1, 0);
    chk("hist4", data, 32'h1CF01C32);
    frame_check("f45", 8'h45, 0, 1'b1, 0);
    chk("wrap", data, 32'hF01C3245);

    // rejected frames
    frame_check("perr", 8'h1C, 1, 1'b1, 0);
    frame_check("serr", 8'h1C, 0, 1'b0, 0);

    // timeout: start + 4 data bits, then idle
    f = mk_frame(8'h29, 0, 1'b1);
    bv0 = nbv; fe0 = nfe;
    for (int i = 0; i < 5; i++) send_bit(f[i], 0);
    t0 = last_fall;
    for (int i = 0; i < TO + 300 && nfe == fe0; i++) tick(1);
    dly = fe_cyc - t0;
    chk("tout.fe", nfe - fe0, 1);
    chk("tout.dly_ok", {31'd0, (nfe != fe0) && dly >= TO && dly <= TO + 20}, 32'd1);
    chk("tout.bv", nbv - bv0, 0);
    chk("tout.data", data, hist);
    tick(20);
    frame_check("f29", 8'h29, 0, 1'b1, 0);
    chk("f29.low", {24'd0, data[7:0]}, 32'h29);

    // glitches while idle (data low so a false edge would look like a start bit)
    ps2_data = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(10); ps2_clk = 1'b0; tick(3); ps2_clk = 1'b1;
    end
    tick(10);
    ps2_data = 1'b1;
    tick(20);
    frame_check("glitch", 8'h1C, 0, 1'b1, 1);

    // randomized frames against the model
    for (int n = 0; n < 16; n++) begin
      rb = 8'($urandom);
      r = int'($urandom_range(0, 7));
      frame_check($sformatf("rnd%0d", n), rb, r == 1, (r == 0) ? 1'b0 : 1'b1, r == 2);
    end

    // async reset after the 5th data bit, then finish that frame without reset
    f = mk_frame(8'hE1, 0, 1'b1);
    for (int i = 0; i < 6; i++) send_bit(f[i], 0);
    #3 reset = 1'b1;
    #1;
    hist = '0; lastb = '0;
    chk("arst.data", data, 32'd0);
    chk("arst.last", {24'd0, last_byte}, 32'd0);
    tick(3);
    reset = 1'b0;
    bv0 = nbv; pe0 = npe; fe0 = nfe;
    for (int i = 6; i < 11; i++) send_bit(f[i], 0);
    tick(HALF);
    chk("arst.nostrb", (nbv - bv0) + (npe - pe0) + (nfe - fe0), 0);
    frame_check("f5a", 8'h5A, 0, 1'b1, 0);
    chk("f5a.data", data, 32'h0000005A);

    chk("onehot", nmulti, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
